// File: rtl/param_risc_core.sv
// Multi-cycle RISC core: FETCH, DECODE, EXEC, optional MEM, WB; 4 cycles per instruction, 4+N for LD/ST.
// RAM request is held stable until a one-cycle ack; the core waits in MEM for as long as the ack takes.
module param_risc_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       rom_data,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d, ram_addr_q, ea_d;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] rdv_q, rsv_q, rtv_q, alu_q, alu_d, ram_wdata_q, imm4;
    logic              take_q, take_d, ram_req_q, ram_we_q, halted_q, wr_en;
    logic [3:0]        op;

    // R0 and indices at or above NREG always read as zero
    function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx);
        return (idx == 4'd0 || int'(idx) >= NREG) ? '0 : regs_q[idx];
    endfunction

    always_comb begin
        op     = ir_q[15:12];
        imm4   = DATA_W'($signed(ir_q[3:0]));
        ea_d   = ADDR_W'(rsv_q + imm4);
        take_d = (rdv_q == rsv_q);
        alu_d  = '0;
        case (op)
            4'h1:    alu_d = rsv_q + rtv_q;
            4'h2:    alu_d = rsv_q - rtv_q;
            4'h3:    alu_d = rsv_q & rtv_q;
            4'h4:    alu_d = rsv_q | rtv_q;
            4'h5:    alu_d = rsv_q ^ rtv_q;
            OP_SLT:  alu_d = ($signed(rsv_q) < $signed(rtv_q)) ? DATA_W'(1) : '0;
            OP_ADDI: alu_d = rsv_q + imm4;
            OP_LDI:  alu_d = DATA_W'(ir_q[7:0]);
            default: alu_d = '0;
        endcase
        pc_d = pc_q + ADDR_W'(1);
        if (op == OP_JMP)
            pc_d = ir_q[ADDR_W-1:0];
        else if (op == OP_BEQ && take_q)
            pc_d = pc_q + ADDR_W'(1) + ADDR_W'($signed(ir_q[3:0]));
        wr_en = ((op >= 4'h1 && op <= OP_LD) || op == OP_LDI) &&
                ir_q[11:8] != 4'd0 && int'(ir_q[11:8]) < NREG;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            rdv_q       <= '0;
            rsv_q       <= '0;
            rtv_q       <= '0;
            alu_q       <= '0;
            take_q      <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            halted_q    <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    ir_q  <= rom_data;
                    rdv_q <= rd_reg(rom_data[11:8]);
                    rsv_q <= rd_reg(rom_data[7:4]);
                    rtv_q <= rd_reg(rom_data[3:0]);
                    if (rom_data[15:12] == OP_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q  <= alu_d;
                    take_q <= take_d;
                    if (op == OP_LD || op == OP_ST) begin
                        state_q    <= S_MEM;
                        ram_req_q  <= 1'b1;
                        ram_we_q   <= (op == OP_ST);
                        ram_addr_q <= ea_d;
                        if (op == OP_ST) ram_wdata_q <= rdv_q;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (ram_ack) begin
                        ram_req_q <= 1'b0;
                        ram_we_q  <= 1'b0;
                        if (op == OP_LD) alu_q <= ram_rdata;
                        state_q   <= S_WB;
                    end
                end
                S_WB: begin
                    if (wr_en) regs_q[ir_q[11:8]] <= alu_q;
                    pc_q    <= pc_d;
                    state_q <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // gated by reset so the strobe stays low while reset holds the FSM in FETCH
    assign rom_en    = (state_q == S_FETCH) && reset;
    assign rom_addr  = pc_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_param_risc_core.sv
// Bench for param_risc_core: ISA-level reference model checked every cycle, plus directed programs.
module tb_param_risc_core;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int NR = 12;
    localparam int DM = (1 << DW) - 1;
    localparam int AM = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   rom_data = 16'h0;
    logic          rom_en, ram_req, ram_we, halted;
    logic [AW-1:0] rom_addr, ram_addr, pc;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_ack = 1'b0;
    logic [2:0]    state;

    param_risc_core #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
        .clk(clk), .reset(reset), .rom_data(rom_data), .rom_en(rom_en), .rom_addr(rom_addr),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .pc(pc), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ROM and RAM behaviour
    logic [15:0]   rom_m [64];
    logic [DW-1:0] bmem [64];
    int ack_dly = 1;
    int mcyc = 0;
    bit stray = 1'b0;
    int req_lens[$];

    always @(posedge clk) if (rom_en) rom_data <= rom_m[rom_addr];

    always @(negedge clk) begin
        if (ram_req) begin
            mcyc++;
            if (mcyc == ack_dly) begin
                ram_ack   = 1'b1;
                ram_rdata = bmem[ram_addr];
                if (ram_we) bmem[ram_addr] = ram_wdata;
                req_lens.push_back(mcyc);
            end else begin
                ram_ack = stray;
            end
        end else begin
            mcyc    = 0;
            ram_ack = stray;
        end
    end

    // Architectural reference model
    int m_pc, ph, cyc, halt_cyc;
    int m_reg [16];
    int m_ram [64];
    logic [15:0] m_ins;
    int fetch_cyc[$];
    bit chk_en = 1'b0;

    function automatic int rreg(input int i);
        return (i == 0 || i >= NR) ? 0 : m_reg[i];
    endfunction
    function automatic int sx(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction
    function automatic int ea_of(input logic [15:0] ins);
        return (rreg(int'(ins[7:4])) + sx(int'(ins[3:0]), 4)) & AM;
    endfunction

    task automatic isa_step();
        int op, rd, a, b, d, im, res, npc;
        bit wr;
        op = int'(m_ins[15:12]); rd = int'(m_ins[11:8]);
        a = rreg(int'(m_ins[7:4])); b = rreg(int'(m_ins[3:0])); d = rreg(rd);
        im = sx(int'(m_ins[3:0]), 4);
        res = 0; wr = 1'b1; npc = (m_pc + 1) & AM;
        case (op)
            1: res = a + b;
            2: res = a - b;
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = (sx(a, DW) < sx(b, DW)) ? 1 : 0;
            7: res = a + im;
            8: res = m_ram[ea_of(m_ins)];
            12: res = int'(m_ins[7:0]);
            default: wr = 1'b0;
        endcase
        if (op == 9) m_ram[ea_of(m_ins)] = d;
        if (op == 10 && d == a) npc = (m_pc + 1 + im) & AM;
        if (op == 11) npc = int'(m_ins[11:0]) & AM;
        if (wr && rd != 0 && rd < NR) m_reg[rd] = res & DM;
        m_pc = npc;
    endtask

    task automatic model_init();
        m_pc = 0; ph = 0; cyc = 0; halt_cyc = 0;
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        fetch_cyc.delete();
        req_lens.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                cyc++;
                chk("state", int'(state), ph);
                chk("pc", int'(pc), m_pc);
                chk("rom_addr", int'(rom_addr), m_pc);
                chk("rom_en", int'(rom_en), int'(ph == 0));
                chk("ram_req", int'(ram_req), int'(ph == 3));
                chk("halted", int'(halted), int'(ph == 5));
                if (ph == 0) fetch_cyc.push_back(cyc);
                if (halted && halt_cyc == 0) halt_cyc = cyc;
                case (ph)
                    0: ph = 1;
                    1: begin
                        m_ins = rom_m[m_pc];
                        ph = (m_ins[15:12] == 4'hF) ? 5 : 2;
                    end
                    2: ph = (m_ins[15:12] == 4'h8 || m_ins[15:12] == 4'h9) ? 3 : 4;
                    3: begin
                        chk("ram_we", int'(ram_we), int'(m_ins[15:12] == 4'h9));
                        chk("ram_addr", int'(ram_addr), ea_of(m_ins));
                        if (m_ins[15:12] == 4'h9)
                            chk("ram_wdata", int'(ram_wdata), rreg(int'(m_ins[11:8])));
                        if (ram_ack) ph = 4;
                    end
                    4: begin isa_step(); ph = 0; end
                    default: ph = 5;
                endcase
            end
        end
    end

    task automatic begin_test();
        chk_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) rom_m[i] = 16'hF000;
    endtask

    task automatic release_reset();
        @(negedge clk);
        model_init();
        reset  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic wait_halt(input string nm, input int maxc);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk(nm, int'(halted), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            bmem[i]  = 8'hEE;
            m_ram[i] = 8'hEE;
        end
        #1 reset = 1'b0;
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_ram_req", int'(ram_req), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_wdata", int'(ram_wdata), 0);
        chk("rst_halted", int'(halted), 0);

        // LDI/LDI/SUB/HALT timing
        begin_test();
        rom_m[0] = 16'hC105; rom_m[1] = 16'hC203; rom_m[2] = 16'h2312; rom_m[3] = 16'hF000;
        release_reset();
        wait_halt("t1_halt", 40);
        chk("t1_halt_cycle", halt_cyc, 15);
        chk("t1_pc", int'(pc), 3);

        // ST/LD with a 3-cycle ack delay
        begin_test();
        ack_dly = 3;
        rom_m[0] = 16'hC42A; rom_m[1] = 16'hC510; rom_m[2] = 16'h9453;
        rom_m[3] = 16'h8653; rom_m[4] = 16'h965F; rom_m[5] = 16'hF000;
        release_reset();
        wait_halt("t2_halt", 100);
        chk("t2_st_mem", int'(bmem[19]), 8'h2A);
        chk("t2_ld_copy", int'(bmem[15]), 8'h2A);
        chk("t2_req_len0", req_lens[0], 3);
        chk("t2_req_len1", req_lens[1], 3);
        chk("t2_req_len2", req_lens[2], 3);
        chk("t2_st_cycles", fetch_cyc[3] - fetch_cyc[2], 7);
        chk("t2_ld_cycles", fetch_cyc[4] - fetch_cyc[3], 7);

        // BEQ loop back to itself
        begin_test();
        rom_m[0] = 16'hA00F;
        release_reset();
        repeat (13) @(negedge clk);
        #2;
        chk("t3_fetch2", fetch_cyc[1], 5);
        chk("t3_fetch3", fetch_cyc[2], 9);
        chk("t3_pc", int'(pc), 0);

        // BEQ forward at pc 63 wraps to 1
        begin_test();
        rom_m[0] = 16'hB03F; rom_m[63] = 16'hA001; rom_m[1] = 16'hF000;
        release_reset();
        wait_halt("t3b_halt", 40);
        chk("t3b_pc", int'(pc), 1);

        // 8-bit arithmetic, R0, out-of-range register, address wrap, single-cycle ack
        begin_test();
        ack_dly = 1;
        rom_m[0]  = 16'hC1FF; rom_m[1]  = 16'hC202; rom_m[2]  = 16'h1312;
        rom_m[3]  = 16'hC480; rom_m[4]  = 16'hC501; rom_m[5]  = 16'h6645;
        rom_m[6]  = 16'hC007; rom_m[7]  = 16'hCD55; rom_m[8]  = 16'h7117;
        rom_m[9]  = 16'h9308; rom_m[10] = 16'h9601; rom_m[11] = 16'h9002;
        rom_m[12] = 16'h9D03; rom_m[13] = 16'h9104; rom_m[14] = 16'hF000;
        release_reset();
        wait_halt("t4_halt", 200);
        chk("t4_add_wrap", int'(bmem[56]), 1);
        chk("t4_slt", int'(bmem[1]), 1);
        chk("t4_r0", int'(bmem[2]), 0);
        chk("t4_r13", int'(bmem[3]), 0);
        chk("t4_addi", int'(bmem[4]), 6);
        chk("t4_req_len", req_lens[0], 1);

        // reset while stalled in MEM
        begin_test();
        ack_dly = 1000;
        rom_m[0] = 16'hC5AB; rom_m[1] = 16'h8607;
        release_reset();
        for (int n = 0; n < 40 && ram_req !== 1'b1; n++) @(negedge clk);
        chk("t5_req_seen", int'(ram_req), 1);
        repeat (2) @(negedge clk);
        #2;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("t5_req_drop", int'(ram_req), 0);
        chk("t5_pc", int'(pc), 0);
        chk("t5_state", int'(state), 0);
        for (int i = 0; i < 64; i++) rom_m[i] = 16'hF000;
        rom_m[0] = 16'h9505; rom_m[1] = 16'h9606;
        ack_dly = 2;
        release_reset();
        wait_halt("t5_halt", 60);
        chk("t5_r5_cleared", int'(bmem[5]), 0);
        chk("t5_r6_cleared", int'(bmem[6]), 0);
        chk("t5_first_fetch", fetch_cyc[0], 1);

        // JMP to 63, HALT, stray ack
        begin_test();
        rom_m[0] = 16'hB03F; rom_m[63] = 16'hF000;
        release_reset();
        wait_halt("t6_halt", 40);
        chk("t6_pc", int'(pc), 63);
        @(posedge clk); #2 stray = 1'b1;
        @(posedge clk); #2 stray = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("t6_state", int'(state), 5);
        chk("t6_pc_after", int'(pc), 63);
        chk("t6_req", int'(ram_req), 0);
        chk("t6_we", int'(ram_we), 0);
        chk("t6_addr", int'(ram_addr), 0);
        chk("t6_wdata", int'(ram_wdata), 0);
        chk("t6_halted", int'(halted), 1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
